// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 register indices, exception codes and packed layouts of the pipe exception word, Status and Cause.
// The timer registers are reported as writable only when CP0_TIMER_INT_EN is defined.
package cp0_exception_unit_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic interrupt;
        logic if_adel;
        logic ri;
        logic ov;
        logic syscall;
        logic brk;
        logic eret;
        logic wr_ades;
        logic rd_adel;
    } ExceptinPipeType;

    typedef struct packed {
        logic [8:0] zero_hi;
        logic       bev;
        logic [5:0] zero_mid;
        logic [7:0] im;
        logic [5:0] zero_lo;
        logic       exl;
        logic       ie;
    } CP0StatusType;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_hi;
        logic [7:0]  ip;
        logic        zero_mid;
        logic [4:0]  exc_code;
        logic [1:0]  zero_lo;
    } CP0CauseType;

    // Software-writable bits of each register; zero means not writable (or not present).
    function automatic logic [31:0] cp0_wr_mask(input logic [4:0] rd, input logic [2:0] sel);
        logic [31:0] m;
        m = '0;
        if (sel == 3'd0) begin
            case (rd)
                CP0_STATUS:  m = 32'h0000_FF03;
                CP0_CAUSE:   m = 32'h0000_0300;
                CP0_EPC:     m = 32'hFFFF_FFFF;
`ifdef CP0_TIMER_INT_EN
                CP0_COUNT:   m = 32'hFFFF_FFFF;
                CP0_COMPARE: m = 32'hFFFF_FFFF;
`endif
                default:     m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// Count/Compare timer: Count advances every second clock, pending latches on Count==Compare.
// Latency: pending is visible one clock after the match; a Compare write clears it and beats a same-cycle match.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_wr,
    input  logic        i_compare_wr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (i_count_wr) begin
                r_count <= i_wdata;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick)
                    r_count <= r_count + 32'd1;
            end
            if (i_compare_wr) begin
                r_compare <= i_wdata;
                r_pending <= 1'b0;
            end else if (r_count == r_compare) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception resolver in MEM: prioritises exceptions/ERET, owns CP0 registers, drives flushes (timer under CP0_TIMER_INT_EN).
// Latency: exception/flush/redirect outputs and MFC0 data are combinational; CP0 state updates on the next clock.
// Backpressure: none; flushes are asserted in the same cycle the exception or ERET is taken.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [8:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_IsDelaySlot,
    input  logic [31:0] MEM_ALUOut,
    input  logic [5:0]  Ext_Int,
    input  logic [4:0]  MEM_CP0RdAddr,
    input  logic [2:0]  MEM_CP0RdSel,
    output logic [31:0] CP0_RdData,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [2:0]  WB_Sel,
    input  logic [31:0] WB_OutB,
    output logic [8:0]  MEM_ExceptType_final,
    output logic        Exc_Valid,
    output logic [31:0] Exc_NPC,
    output logic        IFID_Flush,
    output logic        IDEXE_Flush,
    output logic        EXEMEM_Flush,
    output logic        MEMWB_Flush
);

    CP0StatusType    r_status;
    CP0CauseType     r_cause;
    logic [31:0]     r_epc;
    logic [31:0]     r_badvaddr;

    ExceptinPipeType w_et;
    CP0CauseType     w_cause_rd;
    logic [31:0]     w_wr_mask;
    logic [31:0]     w_rd_mask;
    logic [31:0]     w_rd_data;
    logic            w_wr_en;
    logic            w_int_take;
    logic            w_exc_any;
    logic            w_exc_take;
    logic            w_eret_take;
    logic [4:0]      w_exc_code;
    logic            w_bad_wr;
    logic [31:0]     w_bad_val;
    logic            w_unused_int_in;

    assign w_et            = ExceptinPipeType'(MEM_ExceptType);
    assign w_unused_int_in = w_et.interrupt;
    assign w_wr_mask       = cp0_wr_mask(WB_Dst, WB_Sel);
    assign w_wr_en         = WB_CP0Wr && (w_wr_mask != '0);

`ifdef CP0_TIMER_INT_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_pend;

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_wr   (w_wr_en && WB_Dst == CP0_COUNT),
        .i_compare_wr (w_wr_en && WB_Dst == CP0_COMPARE),
        .i_wdata      (WB_OutB),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pending    (w_timer_pend)
    );
`endif

    // IP7 and TI come straight from the timer when it exists; otherwise IP7 is the registered Ext_Int[5].
    always_comb begin
        w_cause_rd = r_cause;
`ifdef CP0_TIMER_INT_EN
        w_cause_rd.ip[7] = w_timer_pend;
        w_cause_rd.ti    = w_timer_pend;
`endif
    end

    assign w_int_take = MEM_Valid & r_status.ie & ~r_status.exl & (|(w_cause_rd.ip & r_status.im));

    always_comb begin
        w_exc_any  = 1'b1;
        w_exc_code = EXC_INT;
        w_bad_wr   = 1'b0;
        w_bad_val  = MEM_ALUOut;
        if (w_int_take) begin
            w_exc_code = EXC_INT;
        end else if (w_et.if_adel) begin
            w_exc_code = EXC_ADEL;
            w_bad_wr   = 1'b1;
            w_bad_val  = MEM_PC;
        end else if (w_et.ri) begin
            w_exc_code = EXC_RI;
        end else if (w_et.ov) begin
            w_exc_code = EXC_OV;
        end else if (w_et.syscall) begin
            w_exc_code = EXC_SYS;
        end else if (w_et.brk) begin
            w_exc_code = EXC_BP;
        end else if (w_et.rd_adel) begin
            w_exc_code = EXC_ADEL;
            w_bad_wr   = 1'b1;
        end else if (w_et.wr_ades) begin
            w_exc_code = EXC_ADES;
            w_bad_wr   = 1'b1;
        end else begin
            w_exc_any = 1'b0;
        end
    end

    assign w_exc_take  = MEM_Valid & w_exc_any;
    assign w_eret_take = MEM_Valid & w_et.eret & ~w_exc_any;

    assign MEM_ExceptType_final = {w_int_take, MEM_ExceptType[7:0]};
    assign Exc_Valid    = w_exc_take | w_eret_take;
    assign Exc_NPC      = w_exc_take ? EXC_VECTOR : (w_eret_take ? r_epc : 32'd0);
    assign IFID_Flush   = Exc_Valid;
    assign IDEXE_Flush  = Exc_Valid;
    assign EXEMEM_Flush = Exc_Valid;
    assign MEMWB_Flush  = Exc_Valid;

    // Statement order matters: WB write, then sampled IP lines, then exception fields override.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= CP0StatusType'(STATUS_RST);
            r_cause    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else begin
            if (w_wr_en && WB_Dst == CP0_STATUS)
                r_status <= CP0StatusType'((r_status & ~w_wr_mask) | (WB_OutB & w_wr_mask));
            if (w_wr_en && WB_Dst == CP0_CAUSE)
                r_cause <= CP0CauseType'((r_cause & ~w_wr_mask) | (WB_OutB & w_wr_mask));
            if (w_wr_en && WB_Dst == CP0_EPC)
                r_epc <= WB_OutB;
            r_cause.ip[7:2] <= Ext_Int;
            if (w_exc_take) begin
                r_status.exl     <= 1'b1;
                r_cause.bd       <= MEM_IsDelaySlot;
                r_cause.exc_code <= w_exc_code;
                r_epc            <= MEM_IsDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                if (w_bad_wr)
                    r_badvaddr <= w_bad_val;
            end else if (w_eret_take) begin
                r_status.exl <= 1'b0;
            end
        end
    end

    assign w_rd_mask = cp0_wr_mask(MEM_CP0RdAddr, MEM_CP0RdSel);

    always_comb begin
        w_rd_data = '0;
        if (WB_CP0Wr && WB_Dst == MEM_CP0RdAddr && WB_Sel == MEM_CP0RdSel && w_rd_mask != '0) begin
            w_rd_data = WB_OutB & w_rd_mask;
        end else if (MEM_CP0RdSel == 3'd0) begin
            case (MEM_CP0RdAddr)
                CP0_BADVADDR: w_rd_data = r_badvaddr;
                CP0_STATUS:   w_rd_data = r_status;
                CP0_CAUSE:    w_rd_data = w_cause_rd;
                CP0_EPC:      w_rd_data = r_epc;
`ifdef CP0_TIMER_INT_EN
                CP0_COUNT:    w_rd_data = w_count;
                CP0_COMPARE:  w_rd_data = w_compare;
`endif
                default:      w_rd_data = '0;
            endcase
        end
    end

    assign CP0_RdData = w_rd_data;

endmodule
